// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - UART frame transmitter: start, LSB-first data, optional parity, stop.
// Optional build macro UART_TX_STOP2_EN selects two stop bits instead of one.
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
`ifdef UART_TX_STOP2_EN
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(1);
`else
  localparam logic [CNT_W-1:0] STOP_LAST = '0;
`endif

  logic [2:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  par_xor_q, par_xor_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    par_xor_d = par_xor_q;
    case (state_q)
      S_IDLE: begin
        // Requests outside IDLE are dropped; only this branch samples the inputs.
        if (DATA_VALID) begin
          shift_d   = P_DATA;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          par_xor_d = ^P_DATA;
          state_d   = S_START;
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_DATA;
      end
      S_DATA: begin
        shift_d = shift_q >> 1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = par_en_q ? S_PARITY : S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PARITY: begin
        cnt_d   = '0;
        state_d = S_STOP;
      end
      S_STOP: begin
        if (cnt_q == STOP_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Line level is decoded from the current state and registered, so it trails the state by one edge.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_q != S_IDLE);
    case (state_q)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_q[0];
      S_PARITY: tx_d = par_xor_q ^ par_typ_q;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      par_xor_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      par_xor_q <= par_xor_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign TX_OUT = tx_q;
  assign BUSY   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - directed self-checking bench for uart_tx_frame.
module tb_uart_tx_frame;

  logic       CLK;
  logic       RST;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       TX_OUT;
  logic       BUSY;

  int tests;
  int fails;

`ifdef UART_TX_STOP2_EN
  localparam int STOPS = 2;
`else
  localparam int STOPS = 1;
`endif

  uart_tx_frame #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .TX_OUT     (TX_OUT),
    .BUSY       (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sends one frame and checks every line cycle plus the exact BUSY length.
  task automatic run_frame(input string tag, input logic [7:0] d, input logic pe, input logic pt,
                           input logic exp_par, input logic disturb, output logic [15:0] obs);
    logic [15:0] exp_bits;
    int          len;
    exp_bits = '1;
    obs      = '1;
    exp_bits[0] = 1'b0;
    for (int k = 0; k < 8; k++) exp_bits[1+k] = d[k];
    len = 9;
    if (pe) begin
      exp_bits[len] = exp_par;
      len++;
    end
    len = len + STOPS;
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; DATA_VALID = 1'b1;
    step();
    check({tag, "_accept_tx"}, {15'd0, TX_OUT}, 16'd1);
    check({tag, "_accept_busy"}, {15'd0, BUSY}, 16'd0);
    DATA_VALID = 1'b0;
    for (int i = 0; i < len; i++) begin
      step();
      obs[i] = TX_OUT;
      check($sformatf("%s_tx%0d", tag, i), {15'd0, TX_OUT}, {15'd0, exp_bits[i]});
      check($sformatf("%s_busy%0d", tag, i), {15'd0, BUSY}, 16'd1);
      if (disturb && i == 3) begin
        DATA_VALID = 1'b1; P_DATA = 8'h3C; PAR_TYP = ~pt; PAR_EN = ~pe;
      end
      if (disturb && i == 5) DATA_VALID = 1'b0;
    end
    step();
    check({tag, "_end_busy"}, {15'd0, BUSY}, 16'd0);
    check({tag, "_end_tx"}, {15'd0, TX_OUT}, 16'd1);
  endtask

  initial begin
    logic [15:0] obs;
    tests = 0;
    fails = 0;
    RST = 1'b1; P_DATA = '0; DATA_VALID = 1'b0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    #2;
    check("reset_tx", {15'd0, TX_OUT}, 16'd1);
    check("reset_busy", {15'd0, BUSY}, 16'd0);
    step();
    step();
    RST = 1'b0;
    step();

    // 0xA5 even parity: 0,1,0,1,0,0,1,0,1,0,1
    run_frame("a5_even", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, obs);
    check("a5_even_seq", {5'd0, obs[10:0]}, {5'd0, 11'b10101001010});
    run_frame("a5_odd", 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, obs);
    check("a5_odd_par", {15'd0, obs[9]}, 16'd1);
    run_frame("zero_nopar", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, obs);
    check("zero_nopar_seq", {6'd0, obs[9:0]}, {6'd0, 10'b1000000000});
    run_frame("ff_odd", 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, obs);
    check("ff_odd_par", {15'd0, obs[9]}, 16'd1);

    // Mid-frame request with new data/config must be ignored entirely.
    run_frame("disturb", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, obs);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("no_second_tx%0d", i), {15'd0, TX_OUT}, 16'd1);
      check($sformatf("no_second_busy%0d", i), {15'd0, BUSY}, 16'd0);
    end

    // DATA_VALID held high: exactly one idle-high cycle between frames.
    P_DATA = 8'h00; PAR_EN = 1'b0; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
    step();
    for (int i = 0; i < 9 + STOPS; i++) begin
      step();
      check($sformatf("held_busy%0d", i), {15'd0, BUSY}, 16'd1);
    end
    step();
    check("held_gap_tx", {15'd0, TX_OUT}, 16'd1);
    check("held_gap_busy", {15'd0, BUSY}, 16'd0);
    step();
    check("held_restart_tx", {15'd0, TX_OUT}, 16'd0);
    check("held_restart_busy", {15'd0, BUSY}, 16'd1);
    DATA_VALID = 1'b0;
    for (int i = 0; i < 8 + STOPS; i++) step();
    check("held_tail_busy", {15'd0, BUSY}, 16'd1);
    step();
    check("held_done_busy", {15'd0, BUSY}, 16'd0);
    step();

    // Reset during data bit 3 of 0xA5 (bit 3 is 0).
    P_DATA = 8'hA5; PAR_EN = 1'b1; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
    step();
    DATA_VALID = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("rst_pre_bit3", {15'd0, TX_OUT}, 16'd0);
    #2 RST = 1'b1;
    #1;
    check("rst_async_tx", {15'd0, TX_OUT}, 16'd1);
    check("rst_async_busy", {15'd0, BUSY}, 16'd0);
    step();
    step();
    RST = 1'b0;
    for (int i = 0; i < 14; i++) begin
      step();
      check($sformatf("post_rst_tx%0d", i), {15'd0, TX_OUT}, 16'd1);
      check($sformatf("post_rst_busy%0d", i), {15'd0, BUSY}, 16'd0);
    end

`ifdef UART_TX_STOP2_EN
    // 0x81 no parity: 0,1,0,0,0,0,0,0,1,1,1 across 11 busy cycles.
    run_frame("stop2_81", 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, obs);
    check("stop2_81_seq", {5'd0, obs[10:0]}, {5'd0, 11'b11100000010});
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Serial transmitter for the UART link; the transmit-side counterpart of the receive path's frame/parity checking. It accepts one parallel byte per handshake and shifts out a frame of start bit, data LSB first, optional parity, and stop. The frame is timed on the bit clock, one bit per CLK cycle. It sits between the system register/FIFO side (P_DATA/DATA_VALID) and the TX pin.

## Interface
- DATA_WIDTH, 8, payload bits per frame
- CLK  input  1  bit-rate clock; all state updates on posedge
- RST  input  1  asynchronous, active-high reset
- P_DATA  input  DATA_WIDTH  parallel byte to send; sampled only on acceptance
- DATA_VALID  input  1  request to send P_DATA
- PAR_EN  input  1  1 = parity bit inserted; sampled on acceptance
- PAR_TYP  input  1  0 = even, 1 = odd; sampled on acceptance
- TX_OUT  output  1  serial line, idle high
- BUSY  output  1  high while a frame is in progress

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - TX_OUT=1, BUSY=0.
  - If DATA_VALID=1: latch P_DATA into the shift register, latch PAR_EN/PAR_TYP into config registers, compute parity, go to START.
  - DATA_VALID is ignored in every state other than IDLE. Those requests are dropped, not queued.
- START: TX_OUT=0, BUSY=1. Go to DATA and clear the bit counter.
- DATA:
  - TX_OUT = shift register bit 0, LSB first.
  - Shift right each cycle and increment the counter (width clog2(DATA_WIDTH)).
  - After bit DATA_WIDTH-1: go to PARITY if latched PAR_EN=1, else go to STOP.
- PARITY: TX_OUT = parity bit. Go to STOP.
- Parity rule:
  - even: XOR-reduction of the latched data, so the total count of ones including the parity bit is even.
  - odd: inverse of the even value.
  - Computed from the latched copy only. Later changes to P_DATA, PAR_EN or PAR_TYP during a frame have no effect.
- STOP:
  - TX_OUT=1, BUSY=1. Go to IDLE.
  - With UART_TX_STOP2_EN defined: two stop cycles, counted with the bit counter.
- TX_OUT is driven from a register. There are no combinational paths from inputs to outputs.

## Timing
- Reset (async, immediate): state=IDLE, TX_OUT=1, BUSY=0, shift register=0, counter=0, config registers=0.
- Reset mid-frame: the line returns high and BUSY drops immediately. After release, the block is idle; the aborted frame is not resumed.
- Acceptance at edge N (IDLE, DATA_VALID=1):
  - start bit on TX_OUT and BUSY=1 from edge N+1;
  - data bit k at edge N+2+k;
  - parity (if enabled) at edge N+2+DATA_WIDTH;
  - stop follows.
- Frame length in cycles with BUSY=1: 1 + DATA_WIDTH + PAR_EN + 1 (+1 with UART_TX_STOP2_EN). For DATA_WIDTH=8 that is 10 without parity and 11 with parity.
- BUSY falls on the edge after the last stop cycle. The earliest next acceptance is that same IDLE cycle, so there is at least one idle-high cycle between frames.
- DATA_VALID held continuously high: frames repeat, each separated by exactly one IDLE cycle.

## Configuration
- UART_TX_STOP2_EN:
  - Defined: STOP lasts 2 cycles, so the frame is one cycle longer and BUSY is extended by one cycle.
  - Undefined: a single stop bit.
  - No port or parameter changes either way.

## Test plan
- Reset, then 0xA5 with PAR_EN=1, PAR_TYP=0 pulsed for one cycle -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,0(parity),1(stop); BUSY high for exactly 11 cycles.
- 0xA5 with PAR_EN=1, PAR_TYP=1 -> parity bit 1, all other bits as above.
- 0x00 with PAR_EN=0 -> 0, eight 0s, 1; BUSY high for 10 cycles. Then 0xFF with odd parity -> parity bit 1.
- During a frame, pulse DATA_VALID with 0x3C and change P_DATA/PAR_TYP -> the current frame is unchanged and no second frame is sent. With DATA_VALID held high -> frames are separated by exactly one idle-high cycle.
- Assert RST at the 4th data bit -> TX_OUT=1 and BUSY=0 immediately. After release with DATA_VALID=0, the line stays high.
- With UART_TX_STOP2_EN defined, send 0x81 without parity -> 1+8+2 cycles, with two consecutive stop 1s before BUSY falls.
